friscv_rv32i_fetch: RTL and testbench

FRISCV_RV32I_FETCH -- requirements
Module: friscv_rv32i_fetch

---
 rtl/friscv_rv32i_fetch.sv | 122 ++++++++++++
 tb/tb_friscv_rv32i_fetch.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/friscv_rv32i_fetch.sv
// RV32I instruction fetch stage: credit-limited prefetch into a small FIFO,
// in-order memory responses, and redirect handling that discards stale in-flight reads.
module friscv_rv32i_fetch #(
  parameter int          ADDRW     = 16,
  parameter int unsigned BOOT_ADDR = 0,
  parameter int          XLEN      = 32,
  parameter int          DEPTH     = 4
) (
  input  logic             aclk,
  input  logic             srst,
  input  logic             inst_en,
  input  logic [ADDRW-1:0] inst_addr,
  output logic [XLEN-1:0]  inst_rdata,
  output logic             inst_ready,
  output logic             mem_en,
  output logic [ADDRW-1:0] mem_addr,
  input  logic             mem_ready,
  input  logic             mem_rvalid,
  input  logic [XLEN-1:0]  mem_rdata
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [ADDRW-1:0] BOOT    = ADDRW'(BOOT_ADDR);
  localparam logic [ADDRW-1:0] STEP    = ADDRW'(4);
  localparam logic [CW:0]      DEPTH_W = (CW+1)'(DEPTH);

  typedef enum logic {
    RUN,
    FLUSH
  } state_t;

  state_t           r_state;
  logic [ADDRW-1:0] r_fetch_pc;
  logic [ADDRW-1:0] r_head_pc;
  logic [CW-1:0]    r_outstanding;
  logic [CW-1:0]    r_discard;
  logic [CW-1:0]    r_count;
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [XLEN-1:0]  r_fifo [DEPTH];

  logic          w_run;
  logic          w_redirect;
  logic          w_credit;
  logic          w_xfer;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic [CW-1:0] w_discard_nxt;
  logic [CW-1:0] w_redir_discard;

  assign w_run      = (r_state == RUN);
  assign w_redirect = !srst && w_run && inst_en && (inst_addr != r_head_pc);
  // Words in the FIFO plus reads in flight never exceed DEPTH, so a push always has room.
  assign w_credit   = ({1'b0, r_count} + {1'b0, r_outstanding}) < DEPTH_W;

  assign mem_en     = !srst && w_run && w_credit && !w_redirect;
  assign mem_addr   = r_fetch_pc;
  assign inst_ready = !srst && w_run && (r_count != '0) && inst_en && (inst_addr == r_head_pc);
  assign inst_rdata = r_fifo[r_rptr];

  assign w_xfer          = mem_en && mem_ready;
  assign w_pop           = inst_ready;
  assign w_drop          = mem_rvalid && (r_discard != '0);
  assign w_push          = !srst && mem_rvalid && (r_discard == '0) && !w_redirect;
  assign w_discard_nxt   = r_discard - CW'(w_drop);
  assign w_redir_discard = r_outstanding - CW'(mem_rvalid);

  always_ff @(posedge aclk) begin
    if (w_push) begin
      r_fifo[r_wptr] <= mem_rdata;
    end
  end

  always_ff @(posedge aclk) begin
    if (srst) begin
      r_state       <= RUN;
      r_fetch_pc    <= BOOT;
      r_head_pc     <= BOOT;
      r_outstanding <= '0;
      r_discard     <= '0;
      r_count       <= '0;
      r_wptr        <= '0;
      r_rptr        <= '0;
    end else begin
      r_outstanding <= r_outstanding + CW'(w_xfer) - CW'(mem_rvalid);
      r_discard     <= w_discard_nxt;
      r_count       <= r_count + CW'(w_push) - CW'(w_pop);
      if (w_xfer) begin
        r_fetch_pc <= r_fetch_pc + STEP;
      end
      if (w_pop) begin
        r_head_pc <= r_head_pc + STEP;
        r_rptr    <= r_rptr + PW'(1);
      end
      if (w_push) begin
        r_wptr <= r_wptr + PW'(1);
      end

      // Redirect overrides the normal updates; a response landing this cycle is already stale.
      if (w_redirect) begin
        r_fetch_pc <= inst_addr;
        r_head_pc  <= inst_addr;
        r_count    <= '0;
        r_wptr     <= '0;
        r_rptr     <= '0;
        r_discard  <= w_redir_discard;
        r_state    <= (w_redir_discard != '0) ? FLUSH : RUN;
      end else if (r_state == FLUSH) begin
        if (inst_en) begin
          r_fetch_pc <= inst_addr;
          r_head_pc  <= inst_addr;
        end
        if (w_discard_nxt == '0) begin
          r_state <= RUN;
        end
      end
    end
  end

endmodule

// File: tb/tb_friscv_rv32i_fetch.sv
// Bench for friscv_rv32i_fetch: in-order memory model with programmable latency
// and throttling, plus scoreboards for issued addresses and delivered instruction words.
module tb_friscv_rv32i_fetch;

  localparam int          ADDRW = 16;
  localparam int          XLEN  = 32;
  localparam int          DEPTH = 4;
  localparam logic [15:0] BOOT  = 16'h0000;

  logic             aclk = 1'b0;
  logic             srst;
  logic             inst_en;
  logic [ADDRW-1:0] inst_addr;
  logic [XLEN-1:0]  inst_rdata;
  logic             inst_ready;
  logic             mem_en;
  logic [ADDRW-1:0] mem_addr;
  logic             mem_ready;
  logic             mem_rvalid;
  logic [XLEN-1:0]  mem_rdata;

  friscv_rv32i_fetch #(
    .ADDRW    (ADDRW),
    .BOOT_ADDR(0),
    .XLEN     (XLEN),
    .DEPTH    (DEPTH)
  ) dut (
    .aclk      (aclk),
    .srst      (srst),
    .inst_en   (inst_en),
    .inst_addr (inst_addr),
    .inst_rdata(inst_rdata),
    .inst_ready(inst_ready),
    .mem_en    (mem_en),
    .mem_addr  (mem_addr),
    .mem_ready (mem_ready),
    .mem_rvalid(mem_rvalid),
    .mem_rdata (mem_rdata)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [15:0] addr;
    int unsigned due;
  } req_t;

  req_t        mq[$];
  logic [31:0] sb[$];

  int          n_chk = 0;
  int          n_err = 0;
  int unsigned cyc_n = 0;
  int          first_rdy = -1;
  int          n_acc = 0;
  int          n_xfer = 0;
  int          exp_stale = 0;
  logic [15:0] cpu_pc = BOOT;
  logic [15:0] exp_fetch = BOOT;
  logic [15:0] jump_to = BOOT;
  logic        s_mem_en = 1'b0;
  bit          cpu_en = 1'b0;
  bit          jump = 1'b0;
  bit          rst_drv = 1'b1;
  int unsigned lat = 1;
  int unsigned rdy_pct = 100;

  function automatic logic [31:0] word_at(input logic [15:0] a);
    return {a, ~a} ^ 32'h5A3C_0F96;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc_n);
    end
  endtask

  task automatic cycle_step();
    logic rv;
    logic en_now;
    rv     = !rst_drv && (mq.size() > 0) && (mq[0].due <= cyc_n);
    en_now = jump || cpu_en;
    srst       = rst_drv;
    inst_en    = en_now;
    inst_addr  = jump ? jump_to : cpu_pc;
    mem_ready  = ($urandom_range(99) < rdy_pct);
    mem_rvalid = rv;
    mem_rdata  = rv ? word_at(mq[0].addr) : $urandom;
    #2;
    s_mem_en = mem_en;
    if (rst_drv) begin
      check_eq("rst_quiet", 32'({mem_en, inst_ready}), 32'd0);
    end else begin
      if (cyc_n == 0) begin
        check_eq("boot_mem_en", 32'(mem_en), 32'd1);
        check_eq("boot_addr", 32'(mem_addr), 32'(BOOT));
        check_eq("boot_no_ready", 32'(inst_ready), 32'd0);
      end
      if (jump) check_eq("redir_quiet", 32'({mem_en, inst_ready}), 32'd0);
      else if (exp_stale > 0) check_eq("flush_quiet", 32'({mem_en, inst_ready}), 32'd0);
      if (!en_now) check_eq("idle_no_ready", 32'(inst_ready), 32'd0);

      if (inst_ready) begin
        if (first_rdy < 0) first_rdy = int'(cyc_n);
        n_acc++;
        check_eq("sb_nonempty", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) check_eq("inst_rdata", inst_rdata, sb.pop_front());
        cpu_pc = cpu_pc + 16'd4;
        sb.push_back(word_at(cpu_pc));
      end

      if (mem_en && mem_ready) begin
        n_xfer++;
        check_eq("fetch_addr", 32'(mem_addr), 32'(exp_fetch));
        exp_fetch = exp_fetch + 16'd4;
        mq.push_back('{mem_addr, cyc_n + lat});
      end

      if (rv) begin
        void'(mq.pop_front());
        if (!jump && exp_stale > 0) exp_stale--;
      end

      if (jump) begin
        exp_stale = mq.size();
        exp_fetch = jump_to;
        cpu_pc    = jump_to;
        sb.delete();
        sb.push_back(word_at(jump_to));
        jump = 1'b0;
      end

      check_eq("outstanding_le_depth", 32'(mq.size() <= DEPTH), 32'd1);
    end

    @(posedge aclk);
    #1;
    if (rst_drv) begin
      mq.delete();
      sb.delete();
      exp_stale = 0;
      exp_fetch = BOOT;
      cpu_pc    = BOOT;
      sb.push_back(word_at(BOOT));
      cyc_n     = 0;
      first_rdy = -1;
      n_acc     = 0;
      n_xfer    = 0;
    end else begin
      cyc_n++;
    end
  endtask

  task automatic do_reset(input int cycles);
    rst_drv = 1'b1;
    repeat (cycles) cycle_step();
    rst_drv = 1'b0;
  endtask

  task automatic redirect(input logic [15:0] target);
    jump_to = target;
    jump    = 1'b1;
    cycle_step();
  endtask

  initial begin
    srst = 1'b1; inst_en = 1'b0; inst_addr = '0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;

    // Sequential fetch, 1-cycle memory: ready first at cycle 2, then every cycle
    cpu_en = 1'b1; lat = 1; rdy_pct = 100;
    do_reset(3);
    repeat (22) cycle_step();
    check_eq("seq_first_ready", 32'(first_rdy), 32'd2);
    check_eq("seq_accepts", 32'(n_acc), 32'd20);

    // Consumer idle: exactly DEPTH transfers, then no requests until a pop
    cpu_en = 1'b0;
    do_reset(2);
    repeat (12) cycle_step();
    check_eq("full_xfers", 32'(n_xfer), 32'd4);
    check_eq("full_mem_en", 32'(s_mem_en), 32'd0);
    cpu_en = 1'b1;
    repeat (20) cycle_step();
    check_eq("full_drain_accepts", 32'(n_acc), 32'd20);

    // Redirect with three requests in flight and none returning on the redirect cycle
    cpu_en = 1'b0; lat = 4;
    do_reset(2);
    repeat (3) cycle_step();
    cpu_en = 1'b1;
    redirect(16'h0100);
    check_eq("redir_discard", 32'(exp_stale), 32'd3);
    repeat (16) cycle_step();
    check_eq("redir_accepts", 32'(n_acc > 0), 32'd1);

    // Redirect coinciding with a response
    cpu_en = 1'b0; lat = 2;
    do_reset(2);
    repeat (2) cycle_step();
    cpu_en = 1'b1;
    redirect(16'h0200);
    check_eq("redir_rv_discard", 32'(exp_stale), 32'd1);
    repeat (12) cycle_step();
    check_eq("redir_rv_accepts", 32'(n_acc > 0), 32'd1);

    // Throttled memory and consumer, with a redirect that wraps the address space
    lat = 3; rdy_pct = 50; cpu_en = 1'b1;
    do_reset(2);
    for (int i = 0; i < 400; i++) begin
      cpu_en = ($urandom_range(99) < 70);
      if (i == 200) redirect(16'hFFF0);
      else cycle_step();
    end
    check_eq("throttle_accepts", 32'(n_acc > 50), 32'd1);

    // Reset while flushing
    lat = 4; rdy_pct = 100; cpu_en = 1'b0;
    do_reset(2);
    repeat (3) cycle_step();
    cpu_en = 1'b1;
    redirect(16'h0100);
    repeat (2) cycle_step();
    check_eq("midflush_pending", 32'(exp_stale > 0), 32'd1);
    do_reset(1);
    repeat (20) cycle_step();
    check_eq("post_rst_first_ready", 32'(first_rdy >= 5 && first_rdy <= 8), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
